// File: rtl/alu_code_pkg.sv
// Shared opcode encodings and flag bit positions for the alu_code datapath.
// The optional ALU_CODE_SAT_EN build only changes ADD/SUB results in alu_code_comb.
package alu_code_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_code_comb.sv
// Purely combinational result/flag generator for alu_code.
// ALU_CODE_SAT_EN: ADD clamps to 8'hFF on carry, SUB clamps to 8'h00 on borrow.
module alu_code_comb
    import alu_code_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [2:0] opcode_i,
    output logic [7:0] x_o,
    output logic [3:0] flag_o
);

    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] res;
    logic       c;
    logic       v;

    // Bit 8 of diff is the borrow: set exactly when a < b unsigned.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res = 8'h00;
        c   = 1'b0;
        v   = 1'b0;
        case (opcode_i)
            OP_ADD: begin
`ifdef ALU_CODE_SAT_EN
                res = sum[8] ? 8'hFF : sum[7:0];
`else
                res = sum[7:0];
`endif
                c = sum[8];
                v = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
            end
            OP_SUB: begin
`ifdef ALU_CODE_SAT_EN
                res = diff[8] ? 8'h00 : diff[7:0];
`else
                res = diff[7:0];
`endif
                c = diff[8];
                v = (a_i[7] != b_i[7]) && (diff[7] != a_i[7]);
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_NOT: res = ~a_i;
            OP_SHL: begin
                res = {a_i[6:0], 1'b0};
                c   = a_i[7];
            end
            OP_SHR: begin
                res = {1'b0, a_i[7:1]};
                c   = a_i[0];
            end
        endcase
    end

    // Z and N always come from the value actually written (post-saturation).
    always_comb begin
        flag_o         = 4'h0;
        flag_o[FLAG_Z] = (res == 8'h00);
        flag_o[FLAG_N] = res[7];
        flag_o[FLAG_C] = c;
        flag_o[FLAG_V] = v;
    end

    assign x_o = res;

endmodule

// File: rtl/alu_code.sv
// Registered 8-bit ALU: one op per cycle, 1-cycle latency, async active-low reset.
// No handshake; ALU_CODE_SAT_EN selects saturating ADD/SUB inside alu_code_comb.
module alu_code
    import alu_code_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] opcode,
    output logic [7:0] x,
    output logic [3:0] flag
);

    logic [7:0] x_d;
    logic [7:0] x_q;
    logic [3:0] flag_d;
    logic [3:0] flag_q;

    alu_code_comb u_comb (
        .a_i      (a),
        .b_i      (b),
        .opcode_i (opcode),
        .x_o      (x_d),
        .flag_o   (flag_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= 8'h00;
            flag_q <= 4'h0;
        end else begin
            x_q    <= x_d;
            flag_q <= flag_d;
        end
    end

    assign x    = x_q;
    assign flag = flag_q;

endmodule

// File: tb/tb_alu_code.sv
// Self-checking bench for alu_code: directed vector table, reset sequences,
// and a random back-to-back stream checked through an expected-value queue.
module tb_alu_code;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opcode;
    logic [7:0] x;
    logic [3:0] flag;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp_x;
        logic [3:0] exp_f;
    } vec_t;

    vec_t vecs[15];

    alu_code dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .x      (x),
        .flag   (flag)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] ax, input logic [3:0] af,
                         input logic [7:0] ex, input logic [3:0] ef);
        checks++;
        if (ax !== ex || af !== ef) begin
            errors++;
            $display("FAIL %s: got x=%02h flag=%04b, expected x=%02h flag=%04b", name, ax, af, ex, ef);
        end
    endtask

    // Independent reference using signed/unsigned integer arithmetic; flags {V,C,N,Z}.
    function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] op);
        int ua, ub, sa, sb, r, sr;
        logic [7:0] rx;
        logic c, v;
        ua = int'(ma); ub = int'(mb);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 1'b0; v = 1'b0; rx = 8'h00;
        case (op)
            3'd0: begin
                r = ua + ub; sr = sa + sb;
                c = (r > 255); v = (sr > 127) || (sr < -128);
                rx = 8'(r % 256);
`ifdef ALU_CODE_SAT_EN
                if (c) rx = 8'hFF;
`endif
            end
            3'd1: begin
                r = ua - ub; sr = sa - sb;
                c = (ua < ub); v = (sr > 127) || (sr < -128);
                rx = 8'((r + 256) % 256);
`ifdef ALU_CODE_SAT_EN
                if (c) rx = 8'h00;
`endif
            end
            3'd2: rx = ma & mb;
            3'd3: rx = ma | mb;
            3'd4: rx = ma ^ mb;
            3'd5: rx = 8'(255 - ua);
            3'd6: begin rx = 8'((ua * 2) % 256); c = (ua >= 128); end
            default: begin rx = 8'(ua / 2); c = (ua % 2 == 1); end
        endcase
        return {rx, v, c, rx[7], rx == 8'h00};
    endfunction

    // driver: present inputs on the falling edge, sample 1 ns after the rising edge
    task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic [2:0] dop);
        @(negedge clk);
        a = da; b = db; opcode = dop;
    endtask

    task automatic step_and_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] e;
        a = 8'h00; b = 8'h00; opcode = 3'd0; rst_n = 1'b0;

        vecs[0]  = '{8'd10, 8'd5, 3'd0, 8'd15,  4'b0000};
        vecs[1]  = '{8'd10, 8'd5, 3'd1, 8'd5,   4'b0000};
        vecs[2]  = '{8'd10, 8'd5, 3'd2, 8'd0,   4'b0001};
        vecs[3]  = '{8'd10, 8'd5, 3'd3, 8'd15,  4'b0000};
        vecs[4]  = '{8'd10, 8'd5, 3'd4, 8'd15,  4'b0000};
        vecs[5]  = '{8'd10, 8'd5, 3'd5, 8'hF5,  4'b0010};
        vecs[6]  = '{8'd10, 8'd5, 3'd6, 8'd20,  4'b0000};
        vecs[7]  = '{8'd10, 8'd5, 3'd7, 8'd5,   4'b0000};
        vecs[8]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 4'b1010};
`ifdef ALU_CODE_SAT_EN
        vecs[9]  = '{8'hFF, 8'h01, 3'd0, 8'hFF, 4'b0110};
        vecs[10] = '{8'd5,  8'd10, 3'd1, 8'h00, 4'b0101};
`else
        vecs[9]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 4'b0101};
        vecs[10] = '{8'd5,  8'd10, 3'd1, 8'hFB, 4'b0110};
`endif
        vecs[11] = '{8'h80, 8'h01, 3'd1, 8'h7F, 4'b1000};
        vecs[12] = '{8'h81, 8'h00, 3'd6, 8'h02, 4'b0100};
        vecs[13] = '{8'h81, 8'h00, 3'd7, 8'h40, 4'b0100};
        vecs[14] = '{8'hFF, 8'h00, 3'd5, 8'h00, 4'b0001};

        // reset state, held across an edge
        #12;
        check("reset_initial", x, flag, 8'h00, 4'h0);
        step_and_sample();
        check("reset_held", x, flag, 8'h00, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            step_and_sample();
            check($sformatf("vec%0d", i), x, flag, vecs[i].exp_x, vecs[i].exp_f);
        end

        // async reset mid-cycle with nonzero outputs
        drive(8'h7F, 8'h01, 3'd0);
        step_and_sample();
        check("pre_reset", x, flag, 8'h80, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", x, flag, 8'h00, 4'h0);
        step_and_sample();
        check("reset_held_mid", x, flag, 8'h00, 4'h0);
        drive(8'd3, 8'd4, 3'd0);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", x, flag, 8'h00, 4'h0);
        step_and_sample();
        check("first_capture", x, flag, 8'd7, 4'b0000);

        // random back-to-back stream through the expected queue
        for (int n = 0; n < 300; n++) begin
            logic [7:0] ra, rb;
            logic [2:0] rop;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 3'(n % 8 == 0 ? $urandom_range(0, 7) : (n + $urandom_range(0, 1)) % 8);
            drive(ra, rb, rop);
            exp_q.push_back(model(ra, rb, rop));
            step_and_sample();
            e = exp_q.pop_front();
            check($sformatf("rand%0d", n), x, flag, e[11:4], e[3:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
